// File: rtl/filter_pkg.sv
// Shared types for the filter frame sequencer: sequencer state, RGB pixel type
// and the kernel border helper.
package filter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } seq_state_e;

    // RGB 8:8:8
    typedef logic [23:0] pixel_t;

    // Number of zero pixels added on each side of the frame for an odd kernel.
    function automatic int unsigned border_width(input int unsigned kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/filter_raster_cnt.sv
// Column/row walker over the zero-padded raster. Reports whether the current
// position is border padding and whether it is the final position.
module filter_raster_cnt #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned BORDER = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic last,
    output logic pad
);

    localparam int unsigned PadW = WIDTH + 2 * BORDER;
    localparam int unsigned PadH = HEIGHT + 2 * BORDER;
    localparam int unsigned ColW = (PadW > 1) ? $clog2(PadW) : 1;
    localparam int unsigned RowW = (PadH > 1) ? $clog2(PadH) : 1;

    localparam logic [ColW-1:0] ColLast = ColW'(PadW - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(PadH - 1);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;

    // Next position: clear on frame start, otherwise step and wrap on advance.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign last = (col_q == ColLast) && (row_q == RowLast);

    // With no border every position is a real pixel.
    if (BORDER == 0) begin : g_no_border
        assign pad = 1'b0;
    end else begin : g_border
        localparam logic [ColW-1:0] ColLo = ColW'(BORDER);
        localparam logic [ColW-1:0] ColHi = ColW'(WIDTH + BORDER);
        localparam logic [RowW-1:0] RowLo = RowW'(BORDER);
        localparam logic [RowW-1:0] RowHi = RowW'(HEIGHT + BORDER);
        assign pad = (row_q < RowLo) || (row_q >= RowHi) ||
                     (col_q < ColLo) || (col_q >= ColHi);
    end

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame sequencer for the 3-channel convolution filter: streams one padded
// frame into the filter, drains it with zero pixels and counts the results.
// Optional FLUSH watchdog: define FILTER_SEQ_TIMEOUT_EN.
module filter_frame_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned FLUSH_MAX   = 4096,
    localparam int unsigned PixCntW    = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               src_valid,
    output logic               src_ready,
    input  pixel_t             src_data,
    output logic               f_ivalid,
    output pixel_t             f_idata,
    input  logic               f_ovalid,
    input  pixel_t             f_odata,
    output logic               o_valid,
    output pixel_t             o_data,
    output logic [PixCntW-1:0] pix_cnt
);

    localparam int unsigned Border = border_width(KERNEL_SIZE);
    localparam logic [PixCntW-1:0] LastCnt = PixCntW'(WIDTH * HEIGHT - 1);

    seq_state_e         state_q, state_d;
    logic [PixCntW-1:0] pix_cnt_q, pix_cnt_d;
    logic               f_ivalid_q, f_ivalid_d;
    pixel_t             f_idata_q, f_idata_d;
    logic               ras_clear, ras_advance, ras_last, ras_pad;
    logic               in_frame;

`ifdef FILTER_SEQ_TIMEOUT_EN
    localparam int unsigned FlushCntW = (FLUSH_MAX > 1) ? $clog2(FLUSH_MAX) : 1;
    localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FLUSH_MAX - 1);
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic                 err_q, err_d;
`endif

    filter_raster_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .BORDER (Border)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (ras_clear),
        .advance (ras_advance),
        .last    (ras_last),
        .pad     (ras_pad)
    );

    assign in_frame = (state_q == StRun) || (state_q == StFlush);

    // Next state, raster stepping, filter input and result counting.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        f_ivalid_d  = 1'b0;
        f_idata_d   = '0;
        ras_clear   = 1'b0;
        ras_advance = 1'b0;
        src_ready   = 1'b0;
`ifdef FILTER_SEQ_TIMEOUT_EN
        err_d       = err_q;
        flush_cnt_d = (state_q == StFlush) ? flush_cnt_q + 1'b1 : '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ras_clear = 1'b1;
                    pix_cnt_d = '0;
`ifdef FILTER_SEQ_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = StRun;
                end
            end
            StRun: begin
                src_ready = !ras_pad;
                if (ras_pad) begin
                    // Border pixel is generated locally as zero.
                    f_ivalid_d  = 1'b1;
                    ras_advance = 1'b1;
                end else if (src_valid) begin
                    f_ivalid_d  = 1'b1;
                    f_idata_d   = src_data;
                    ras_advance = 1'b1;
                end
                if (ras_advance && ras_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // The filter only produces output while it sees input.
                f_ivalid_d = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (in_frame && f_ovalid) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (pix_cnt_q == LastCnt) begin
                state_d = StDone;
            end
        end

`ifdef FILTER_SEQ_TIMEOUT_EN
        if ((state_q == StFlush) && (state_d != StDone) && (flush_cnt_q == FlushLast)) begin
            err_d   = 1'b1;
            state_d = StDone;
        end
`endif

        // Filter input is idle during the DONE cycle.
        if (state_d == StDone) begin
            f_ivalid_d = 1'b0;
            f_idata_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pix_cnt_q  <= '0;
            f_ivalid_q <= 1'b0;
            f_idata_q  <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            f_ivalid_q <= f_ivalid_d;
            f_idata_q  <= f_idata_d;
        end
    end

`ifdef FILTER_SEQ_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign f_ivalid = f_ivalid_q;
    assign f_idata  = f_idata_q;
    assign o_valid  = f_ovalid && in_frame;
    assign o_data   = f_odata;
    assign pix_cnt  = pix_cnt_q;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Self-checking bench for filter_frame_sequencer with a behavioural filter model.
module tb_filter_frame_sequencer;

    localparam int TW   = 4;
    localparam int TH   = 3;
    localparam int PW   = TW + 2;
    localparam int NPOS = (TW + 2) * (TH + 2);
    localparam int NPIX = TW * TH;
    localparam int FMAX = 8;

    logic        clk = 1'b0;
    logic        reset, start, busy, done, err;
    logic        src_valid, src_ready;
    logic [23:0] src_data;
    logic        f_ivalid, f_ovalid, o_valid;
    logic [23:0] f_idata, f_odata, o_data;
    logic [3:0]  pix_cnt;

    always #5 clk = ~clk;

    filter_frame_sequencer #(
        .WIDTH       (TW),
        .HEIGHT      (TH),
        .KERNEL_SIZE (3),
        .FLUSH_MAX   (FMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .f_ivalid  (f_ivalid),
        .f_idata   (f_idata),
        .f_ovalid  (f_ovalid),
        .f_odata   (f_odata),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .pix_cnt   (pix_cnt)
    );

    // Filter model: a 3x3 window result (the centre pixel) becomes available once
    // the window's bottom-right input has arrived, then passes a 2-deep pipeline
    // that only moves while iValid is high; oValid is gated by iValid.
    logic [23:0] fm_recv [64];
    int          fm_k = 0;
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [23:0] p1_d = '0, p2_d = '0;
    logic        force_low = 1'b0;

    function automatic logic win_done(input int k);
        return (k < NPOS) && ((k / PW) >= 2) && ((k % PW) >= 2);
    endfunction

    always @(posedge clk) begin
        if (reset || (start && !busy)) begin
            fm_k <= 0;
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_d <= '0;
            p2_d <= '0;
        end else if (f_ivalid) begin
            if (fm_k < 64) fm_recv[fm_k] <= f_idata;
            fm_k <= fm_k + 1;
            p2_v <= p1_v;
            p2_d <= p1_d;
            p1_v <= win_done(fm_k);
            p1_d <= (fm_k >= PW + 1 && fm_k < 64) ? fm_recv[fm_k-PW-1] : 24'h0;
        end
    end

    assign f_ovalid = f_ivalid && p2_v && !force_low;
    assign f_odata  = p2_d;

    // Bench state and reference model.
    int          checks = 0;
    int          errors = 0;
    logic [23:0] pix [NPIX];
    int          src_idx, in_k, res_j, hs_cnt, gaps, done_cnt, vmode, stall_left;
    bit          glitch, run_glitched, expect_done_next, force_flush;
    logic [3:0]  pc_at_done;
    logic        err_at_done;

    // Expected filter input k of a frame: padded raster, then zero drain.
    function automatic logic [23:0] exp_in(input int k);
        int pr, pc;
        if (k >= NPOS) return 24'h0;
        pr = k / PW;
        pc = k % PW;
        if (pr < 1 || pr > TH || pc < 1 || pc > TW) return 24'h0;
        return pix[(pr - 1) * TW + (pc - 1)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_f_ivalid"}, 32'(f_ivalid), 0);
        chk({tag, "_f_idata"}, 32'(f_idata), 0);
        chk({tag, "_src_ready"}, 32'(src_ready), 0);
        chk({tag, "_o_valid"}, 32'(o_valid), 0);
        chk({tag, "_pix_cnt"}, 32'(pix_cnt), 0);
    endtask

    // One clock: observe at the falling edge, drive just after the rising edge.
    task automatic tick();
        bit hs;
        @(negedge clk);
        hs = src_valid && src_ready;
        if (hs) hs_cnt++;
        if (expect_done_next) begin
            chk("done_after_last_result", 32'(done), 1);
            expect_done_next = 1'b0;
        end
        if (f_ivalid) begin
            chk($sformatf("f_idata[%0d]", in_k), 32'(f_idata), 32'(exp_in(in_k)));
            in_k++;
        end else if (busy && !done && in_k > 0 && in_k < NPOS) begin
            gaps++;
        end
        if (o_valid) begin
            if (res_j < NPIX) chk($sformatf("o_data[%0d]", res_j), 32'(o_data), 32'(pix[res_j]));
            else chk("extra_result", res_j, NPIX - 1);
            res_j++;
            if (res_j == NPIX) expect_done_next = 1'b1;
        end
        if (done) begin
            done_cnt++;
            chk("f_ivalid_in_done", 32'(f_ivalid), 0);
            pc_at_done  = pix_cnt;
            err_at_done = err;
        end
        @(posedge clk);
        #1;
        if (hs) src_idx++;
        start = 1'b0;
        if (glitch && !run_glitched && in_k == 10) begin
            start = 1'b1;
            run_glitched = 1'b1;
        end
        if (glitch && expect_done_next) start = 1'b1;
        force_low = force_flush && (in_k >= NPOS - 1);
        src_data  = (src_idx < NPIX) ? pix[src_idx] : 24'($urandom);
        case (vmode)
            1: begin
                if (src_idx == 5 && stall_left > 0) begin
                    src_valid = 1'b0;
                    stall_left--;
                end else begin
                    src_valid = 1'b1;
                end
            end
            2:       src_valid = ($urandom_range(0, 3) != 0);
            default: src_valid = 1'b1;
        endcase
    endtask

    task automatic frame_init(input int mode, input bit gl, input bit ff);
        vmode = mode;
        glitch = gl;
        force_flush = ff;
        run_glitched = 1'b0;
        stall_left = 5;
        for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom) | 24'h1;
        src_idx = 0;
        in_k = 0;
        res_j = 0;
        hs_cnt = 0;
        gaps = 0;
        done_cnt = 0;
        expect_done_next = 1'b0;
        pc_at_done = '0;
        err_at_done = 1'b0;
        src_data = pix[0];
        src_valid = 1'b1;
    endtask

    task automatic run_frame(input int mode, input bit gl, input bit ff);
        frame_init(mode, gl, ff);
        start = 1'b1;
        tick();
        for (int c = 0; c < 600 && done_cnt == 0; c++) tick();
        chk("done_seen", done_cnt, 1);
        repeat (4) tick();
        chk("done_count", done_cnt, 1);
        chk("busy_after_frame", 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src_valid = 1'b0;
        src_data = '0;
        vmode = 0;
        glitch = 1'b0;
        force_flush = 1'b0;
        expect_done_next = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Always-valid source.
        run_frame(0, 1'b0, 1'b0);
        chk("a_handshakes", hs_cnt, NPIX);
        chk("a_pix_cnt_at_done", 32'(pc_at_done), NPIX);
        chk("a_filter_inputs", in_k, NPOS + 2);
        chk("a_run_gaps", gaps, 0);
        chk("a_err", 32'(err_at_done), 0);

        // Five-cycle source stall at row 2, col 2.
        run_frame(1, 1'b0, 1'b0);
        chk("b_handshakes", hs_cnt, NPIX);
        chk("b_run_gaps", gaps, 5);
        chk("b_pix_cnt_at_done", 32'(pc_at_done), NPIX);

        // Random source valid.
        run_frame(2, 1'b0, 1'b0);
        chk("c_handshakes", hs_cnt, NPIX);
        chk("c_pix_cnt_at_done", 32'(pc_at_done), NPIX);
        chk("c_filter_inputs", in_k, NPOS + 2);

        // start pulsed during RUN and during DONE.
        run_frame(0, 1'b1, 1'b0);
        chk("d_glitch_in_run", 32'(run_glitched), 1);
        chk("d_pix_cnt_at_done", 32'(pc_at_done), NPIX);
        chk("d_filter_inputs", in_k, NPOS + 2);

        // Reset in the middle of a frame, then a full frame.
        frame_init(0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        for (int c = 0; c < 200 && in_k < 15; c++) tick();
        chk("e_reached_pos15", in_k, 15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_quiet_outputs("mid_reset");
        @(posedge clk);
        #1;
        run_frame(2, 1'b0, 1'b0);
        chk("e_handshakes", hs_cnt, NPIX);
        chk("e_pix_cnt_at_done", 32'(pc_at_done), NPIX);

`ifdef FILTER_SEQ_TIMEOUT_EN
        // Results suppressed during FLUSH: watchdog ends the frame.
        run_frame(0, 1'b0, 1'b1);
        chk("f_err_at_done", 32'(err_at_done), 1);
        chk("f_filter_inputs", in_k, NPOS - 1 + FMAX);
        chk("f_pix_cnt_at_done", 32'(pc_at_done), 9);
        chk("f_err_held", 32'(err), 1);
        force_flush = 1'b0;
        force_low = 1'b0;
        run_frame(0, 1'b0, 1'b0);
        chk("g_err_cleared", 32'(err_at_done), 0);
        chk("g_pix_cnt_at_done", 32'(pc_at_done), NPIX);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/filter_frame_sequencer.md
# filter_frame_sequencer

Frame-level controller that drives the 3-channel convolution filter. On `start` it streams one frame into the filter as a zero-padded raster of (HEIGHT+2B) × (WIDTH+2B) pixels, where B = (KERNEL_SIZE−1)/2. Real pixels are pulled from an upstream valid/ready source; the zero border is generated locally. Once the raster is complete, the block keeps clocking zero pixels into the filter until all WIDTH×HEIGHT results have come out, then signals frame completion. It sits between the frame-buffer reader and the filter, and exposes the filter output to the downstream writer.

## Interface
Parameters:
- `WIDTH`, 320: active pixels per row.
- `HEIGHT`, 240: active rows per frame.
- `KERNEL_SIZE`, 3: odd kernel dimension; B = (KERNEL_SIZE−1)/2.
- `FLUSH_MAX`, 4096: watchdog limit, in cycles, for the FLUSH state (used only with `FILTER_SEQ_TIMEOUT_EN`).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle frame request; honoured in IDLE only.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at frame end.
- `err`, out, 1: watchdog fired during the frame just completed; held until the next accepted `start`.
- `src_valid`, in, 1: upstream pixel available.
- `src_ready`, out, 1: combinational; pixel accepted when `src_valid & src_ready`.
- `src_data`, in, 24: RGB 8:8:8.
- `f_ivalid`, out, 1: registered; to the filter's iValid.
- `f_idata`, out, 24: registered; to the filter's iData.
- `f_ovalid`, in, 1: from the filter's oValid.
- `f_odata`, in, 24: from the filter's oData.
- `o_valid`, out, 1: equals `f_ovalid` while in RUN or FLUSH; otherwise 0.
- `o_data`, out, 24: equals `f_odata`.
- `pix_cnt`, out, clog2(WIDTH·HEIGHT+1): number of filter results seen in the current frame.

## Operation
- State machine: IDLE → RUN → FLUSH → DONE → IDLE.
- IDLE: on `start`, clear `col`, `row`, `pix_cnt` and `err`, then go to RUN.
- RUN: the position counters `col` (0..WIDTH+2B−1) and `row` (0..HEIGHT+2B−1) walk the padded raster.
  - A position is padding when `row < B`, `row ≥ HEIGHT+B`, `col < B` or `col ≥ WIDTH+B`.
  - Padding position: the block emits `f_idata = 0` with `f_ivalid = 1` the next cycle and advances unconditionally.
  - Real position: `src_ready = 1`. On handshake, the block emits `src_data` the next cycle with `f_ivalid = 1` and advances. With no handshake, `f_ivalid = 0` the next cycle and the position holds, so the filter stalls.
  - `col` wraps to 0 and increments `row`.
  - Advancing past the last position goes to FLUSH.
- FLUSH: `f_ivalid = 1` and `f_idata = 0` every cycle. This is required because the filter gates its oValid with its internal iValid. `src_ready = 0`.
- Result counting: in RUN and FLUSH, `pix_cnt` increments on each `f_ovalid`. When a result arrives with `pix_cnt == WIDTH·HEIGHT−1`, go to DONE.
- DONE: lasts one cycle. `done = 1` and `f_ivalid = 0`; the state then returns to IDLE.
- `start` outside IDLE is ignored, including in the DONE cycle.
- A `src_valid` assertion that arrives while the current position is padding is not consumed.
- Reset at any point: state goes to IDLE, and `busy`, `done`, `err`, `f_ivalid`, `f_idata`, `src_ready`, `o_valid` and `pix_cnt` all read 0 in the next cycle. The filter shares `reset` and is cleared at the same time.

## Timing
- `src_data` to `f_idata`: 1 cycle.
- The source handshake occurs in the same cycle as the `src_ready` decision.
- One padded pixel per cycle at most. A full frame takes at least (W+2B)·(H+2B) RUN cycles, plus the filter drain, plus 1 DONE cycle.
- `o_valid` and `o_data` are combinational pass-throughs; they add no latency.
- `done` is asserted in the cycle after the final `f_ovalid`.
- `busy` falls together with the end of `done`.

## Configuration
- `FILTER_SEQ_TIMEOUT_EN` defined: a FLUSH cycle counter is compiled in. If FLUSH lasts FLUSH_MAX cycles without completing, the block sets `err = 1` and goes to DONE.
- `FILTER_SEQ_TIMEOUT_EN` not defined: FLUSH has no bound, and `err` is tied to 0.

## Structure
- Shared package `filter_pkg` holds:
  - the state enum {IDLE, RUN, FLUSH, DONE};
  - the pixel type (24-bit RGB);
  - the helper function for the boundary width B.
- Sub-module `filter_raster_cnt`: the `col`/`row` counter with advance enable, wrap, last-position flag and padding flag.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, KERNEL_SIZE=3 (padded raster 6×5 = 30 positions) with the real filter attached.
- Source always valid, `start`: exactly 30 `f_ivalid` pulses in RUN, exactly 12 source handshakes, 12 `o_valid` pulses, `pix_cnt` = 12 at the `done` pulse.
- Padding placement: `f_idata` inputs 0–6 are zero; input 7 is source pixel 0 (position row 1, col 1); inputs 11–12 are zero.
- Source stall: `src_valid` held low for 5 cycles at row 2, col 2. `f_ivalid` is low for those 5 cycles, no padding is inserted, and pixel order is unchanged.
- `start` pulsed in RUN and again in the DONE cycle: both ignored, and exactly one `done` results.
- Reset asserted at position 15: all outputs read 0 the next cycle, and a subsequent `start` yields a full correct frame.
- With `FILTER_SEQ_TIMEOUT_EN` defined and FLUSH_MAX=8, `f_ovalid` forced low in FLUSH: `err = 1` and `done` pulses after exactly 8 FLUSH cycles.
